// File: rtl/extrinsic_interleaver.sv
// Extrinsic computation (Le = LLR - 2*sys - 2*ext, saturated) and fixed 5-entry
// (de-)interleave of one SISO output block into ext_o/sys_o for the next half-iteration.
module extrinsic_interleaver #(
  parameter int DATA_SIZE = 12,
  parameter int BLK       = 7,
  parameter int INFO      = 5,
  parameter logic [3*INFO-1:0] PERM = {3'd2, 3'd4, 3'd1, 3'd3, 3'd0}
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     finish_i,
  input  logic [BLK*DATA_SIZE-1:0] llr_i,
  input  logic [BLK*4-1:0]         sys_i,
  input  logic [BLK*DATA_SIZE-1:0] ext_i,
  input  logic                     mode_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [BLK*DATA_SIZE-1:0] ext_o,
  output logic [BLK*4-1:0]         sys_o,
  output logic                     busy_o,
  output logic                     overrun_o
);

  localparam int DW = DATA_SIZE;
  localparam int TW = DW + 3;
  localparam logic [2:0] INFO3 = 3'(INFO);
  // COMPUTE spans BLK+1 cycles: the final one drains the registered write stage.
  localparam logic [2:0] LAST = 3'(BLK);
  localparam logic signed [TW-1:0] SAT_HI = TW'((1 << (DW-1)) - 1);
  localparam logic signed [TW-1:0] SAT_LO = -TW'(1 << (DW-1));

  typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;

  state_t state, state_n;
  logic [2:0] count, count_n;
  logic capture, ovr_set;

  // Ascending index so entry 0 lands in the MSBs of the flat ports.
  logic [0:BLK-1][DW-1:0] llr_q, ext_q, ext_r;
  logic [0:BLK-1][3:0]    sys_q, sys_r;
  logic                   mode_q;

  logic          wr_vld;
  logic [2:0]    wr_slot;
  logic [DW-1:0] wr_le;
  logic [3:0]    wr_sys;

  function automatic logic [2:0] pi_f(input logic [2:0] k);
    return PERM[3*INFO-1-3*int'(k) -: 3];
  endfunction

  function automatic logic [2:0] pi_inv_f(input logic [2:0] k);
    logic [2:0] r;
    r = '0;
    for (int p = 0; p < INFO; p++)
      if (pi_f(3'(p)) == k) r = 3'(p);
    return r;
  endfunction

  // Per-entry extrinsic at 15 bits, then clamp back to DATA_SIZE.
  logic [2:0]           idx;
  logic signed [TW-1:0] t;
  logic [DW-1:0]        le;

  always_comb begin
    idx = (count < INFO3) ? count : 3'd0;
    t   = $signed({{3{llr_q[idx][DW-1]}}, llr_q[idx]})
        - $signed({{(TW-5){sys_q[idx][3]}}, sys_q[idx], 1'b0})
        - $signed({{2{ext_q[idx][DW-1]}}, ext_q[idx], 1'b0});
    if (t > SAT_HI)      le = SAT_HI[DW-1:0];
    else if (t < SAT_LO) le = SAT_LO[DW-1:0];
    else                 le = t[DW-1:0];
  end

  always_comb begin
    state_n = state;
    count_n = count;
    capture = 1'b0;
    ovr_set = 1'b0;
    case (state)
      IDLE: if (finish_i) begin
        capture = 1'b1;
        state_n = COMPUTE;
        count_n = '0;
      end
      COMPUTE: begin
        ovr_set = finish_i;
        if (count == LAST) state_n = OUTPUT;
        else               count_n = count + 3'd1;
      end
      OUTPUT: begin
        if (ready_i) begin
          if (finish_i) begin
            capture = 1'b1;
            state_n = COMPUTE;
            count_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          ovr_set = finish_i;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= IDLE;
      count     <= '0;
      llr_q     <= '0;
      sys_q     <= '0;
      ext_q     <= '0;
      mode_q    <= 1'b0;
      ext_r     <= '0;
      sys_r     <= '0;
      wr_vld    <= 1'b0;
      wr_slot   <= '0;
      wr_le     <= '0;
      wr_sys    <= '0;
      overrun_o <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      overrun_o <= overrun_o | ovr_set;
      // Tail entries are never written, so they keep the cleared zero.
      wr_vld    <= (state == COMPUTE) && (count < INFO3);
      wr_slot   <= mode_q ? pi_f(idx) : pi_inv_f(idx);
      wr_le     <= le;
      wr_sys    <= sys_q[idx];
      if (capture) begin
        llr_q  <= llr_i;
        sys_q  <= sys_i;
        ext_q  <= ext_i;
        mode_q <= mode_i;
        ext_r  <= '0;
        sys_r  <= '0;
      end else if (wr_vld) begin
        ext_r[wr_slot] <= wr_le;
        sys_r[wr_slot] <= wr_sys;
      end
    end
  end

  assign valid_o = (state == OUTPUT);
  assign busy_o  = (state != IDLE);
  assign ext_o   = ext_r;
  assign sys_o   = sys_r;

endmodule
